// File: rtl/eth_rx_fcs_check.sv
// Receive-side FCS checker/stripper: CRC-32 over every byte incl. FCS, compared to the residue at EOF.
// Latency: payload byte leaves 4 input bytes + 1 clk after it arrives; status pulses 1 clk after EOF.
// Backpressure: none; every RxValid byte is consumed in the cycle it is presented.
module eth_rx_fcs_check #(
  parameter int          MIN_LEN     = 64,
  parameter int          MAX_LEN     = 1518,
  parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_sof,
  input  logic        i_rx_eof,
  output logic [7:0]  o_out_data,
  output logic        o_out_valid,
  output logic        o_out_sof,
  output logic        o_out_eof,
  output logic        o_frame_done,
  output logic        o_fcs_ok,
  output logic        o_fcs_err,
  output logic        o_len_err,
  output logic        o_abort,
  output logic [15:0] o_byte_cnt
);

  localparam logic [15:0] MIN_L = MIN_LEN[15:0];
  localparam logic [15:0] MAX_L = MAX_LEN[15:0];

  typedef enum logic {S_IDLE, S_RECV} state_t;

  // One byte of CRC-32 (poly 0x04C11DB7), data bit 0 shifted in first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  state_t          r_state;
  logic [31:0]     r_crc;
  logic [15:0]     r_byte_cnt;
  logic [3:0][7:0] r_dl;        // [3] newest, [0] oldest once full
  logic [2:0]      r_dl_cnt;
  logic            r_first;     // next byte pushed out is the frame's first
  logic [7:0]      r_out_data;
  logic            r_out_valid;
  logic            r_out_sof;
  logic            r_out_eof;
  logic            r_frame_done;
  logic            r_fcs_ok;
  logic            r_fcs_err;
  logic            r_len_err;
  logic            r_abort;

  logic [31:0] w_crc_seed;
  logic [31:0] w_crc_next;
  logic [15:0] w_cnt_inc;
  logic        w_fcs_bad;
  logic        w_len_bad;
  logic        w_seed_fcs_bad;
  logic        w_one_len_bad;

  // Next-state arithmetic shared by the FSM: CRC for a fresh frame and a continuing one, saturating count.
  always_comb begin
    w_crc_seed     = crc_step(32'hFFFFFFFF, i_rx_data);
    w_crc_next     = crc_step(r_crc, i_rx_data);
    w_cnt_inc      = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;
    w_fcs_bad      = (w_crc_next != CRC_RESIDUE);
    w_len_bad      = (w_cnt_inc < MIN_L) || (w_cnt_inc > MAX_L);
    w_seed_fcs_bad = (w_crc_seed != CRC_RESIDUE);
    w_one_len_bad  = (16'd1 < MIN_L) || (16'd1 > MAX_L);
  end

  // Frame FSM, CRC accumulation, FCS delay line and registered status/data outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_crc        <= 32'hFFFFFFFF;
      r_byte_cnt   <= 16'd0;
      r_dl         <= '0;
      r_dl_cnt     <= 3'd0;
      r_first      <= 1'b0;
      r_out_data   <= 8'd0;
      r_out_valid  <= 1'b0;
      r_out_sof    <= 1'b0;
      r_out_eof    <= 1'b0;
      r_frame_done <= 1'b0;
      r_fcs_ok     <= 1'b0;
      r_fcs_err    <= 1'b0;
      r_len_err    <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_out_sof    <= 1'b0;
      r_out_eof    <= 1'b0;
      r_frame_done <= 1'b0;
      r_fcs_ok     <= 1'b0;
      r_fcs_err    <= 1'b0;
      r_len_err    <= 1'b0;
      r_abort      <= 1'b0;
      if (i_rx_valid) begin
        case (r_state)
          S_IDLE: begin
            if (i_rx_sof) begin
              r_crc      <= w_crc_seed;
              r_byte_cnt <= 16'd1;
              r_dl       <= {i_rx_data, r_dl[3:1]};
              r_first    <= 1'b1;
              if (i_rx_eof) begin
                // Single-byte frame: status only, nothing reaches the output.
                r_frame_done <= 1'b1;
                r_fcs_err    <= w_seed_fcs_bad;
                r_len_err    <= w_one_len_bad;
                r_fcs_ok     <= ~(w_seed_fcs_bad | w_one_len_bad);
                r_dl_cnt     <= 3'd0;
              end else begin
                r_state  <= S_RECV;
                r_dl_cnt <= 3'd1;
              end
            end
          end
          S_RECV: begin
            if (i_rx_sof) begin
              // New SOF before EOF: report abort, drop buffered bytes, start the new frame.
              r_frame_done <= 1'b1;
              r_abort      <= 1'b1;
              r_crc        <= w_crc_seed;
              r_byte_cnt   <= 16'd1;
              r_dl         <= {i_rx_data, r_dl[3:1]};
              r_first      <= 1'b1;
              r_dl_cnt     <= i_rx_eof ? 3'd0 : 3'd1;
              r_state      <= i_rx_eof ? S_IDLE : S_RECV;
            end else begin
              r_crc      <= w_crc_next;
              r_byte_cnt <= w_cnt_inc;
              r_dl       <= {i_rx_data, r_dl[3:1]};
              if (r_dl_cnt == 3'd4) begin
                r_out_data  <= r_dl[0];
                r_out_valid <= 1'b1;
                r_out_sof   <= r_first;
                r_out_eof   <= i_rx_eof;
                r_first     <= 1'b0;
              end else begin
                r_dl_cnt <= r_dl_cnt + 3'd1;
              end
              if (i_rx_eof) begin
                r_state      <= S_IDLE;
                r_dl_cnt     <= 3'd0;
                r_frame_done <= 1'b1;
                r_fcs_err    <= w_fcs_bad;
                r_len_err    <= w_len_bad;
                r_fcs_ok     <= ~(w_fcs_bad | w_len_bad);
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;
  assign o_out_sof    = r_out_sof;
  assign o_out_eof    = r_out_eof;
  assign o_frame_done = r_frame_done;
  assign o_fcs_ok     = r_fcs_ok;
  assign o_fcs_err    = r_fcs_err;
  assign o_len_err    = r_len_err;
  assign o_abort      = r_abort;
  assign o_byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Bench for eth_rx_fcs_check: random frames, reference uses reflected CRC-32 (crc32 of frame+FCS == 0x2144DF1C).
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
// DUT has no backpressure; every wait is a fixed number of cycles.
module tb_eth_rx_fcs_check;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof;
  logic [7:0]  o_out_data;
  logic        o_out_valid, o_out_sof, o_out_eof;
  logic        o_frame_done, o_fcs_ok, o_fcs_err, o_len_err, o_abort;
  logic [15:0] o_byte_cnt;

  always #5 clk = ~clk;

  eth_rx_fcs_check dut (
    .i_clk(clk), .i_reset(reset),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_sof(rx_sof), .i_rx_eof(rx_eof),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .o_out_sof(o_out_sof), .o_out_eof(o_out_eof),
    .o_frame_done(o_frame_done), .o_fcs_ok(o_fcs_ok), .o_fcs_err(o_fcs_err), .o_len_err(o_len_err),
    .o_abort(o_abort), .o_byte_cnt(o_byte_cnt)
  );

  typedef struct packed { logic [7:0] d; logic s; logic e; } ob_t;
  typedef struct packed { logic ok; logic err; logic len; logic ab; logic [15:0] cnt; } st_t;

  ob_t        got_o[$];
  ob_t        exp_o[$];
  st_t        got_s[$];
  st_t        exp_s[$];
  logic [7:0] frm[$];
  int         checks = 0;
  int         errors = 0;
  int         leak = 0;

  // Monitor: collect output bytes and status pulses; count status/framing bits seen without their qualifier.
  always @(negedge clk) begin
    if (o_out_valid) got_o.push_back('{o_out_data, o_out_sof, o_out_eof});
    else if (o_out_sof | o_out_eof) leak++;
    if (o_frame_done) got_s.push_back('{o_fcs_ok, o_fcs_err, o_len_err, o_abort, o_byte_cnt});
    else if (o_fcs_ok | o_fcs_err | o_len_err | o_abort) leak++;
  end

  // Standard reflected Ethernet CRC-32 over frm[0..n-1], with final inversion.
  function automatic logic [31:0] crc32_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Frame of n bytes; for n >= 4 the last four bytes are a correct FCS (LSB first).
  function automatic void build_frame(input int n);
    logic [31:0] c;
    frm.delete();
    if (n < 4) begin
      for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < n - 4; i++) frm.push_back(8'($urandom));
      c = crc32_of(n - 4);
      frm.push_back(c[7:0]);   frm.push_back(c[15:8]);
      frm.push_back(c[23:16]); frm.push_back(c[31:24]);
    end
  endfunction

  // Reference: appends expected output bytes and returns the expected status for the frame in frm.
  function automatic st_t model_frame();
    int  n;
    st_t s;
    n = frm.size();
    for (int i = 0; i < n - 4; i++) exp_o.push_back('{frm[i], i == 0, i == n - 5});
    s.len = (n < 64) || (n > 1518);
    s.err = (crc32_of(n) != 32'h2144DF1C);
    s.ok  = !s.len && !s.err;
    s.ab  = 1'b0;
    s.cnt = (n > 65535) ? 16'hFFFF : 16'(n);
    return s;
  endfunction

  function automatic int out_mism();
    int m;
    m = (got_o.size() != exp_o.size()) ? 1 : 0;
    for (int i = 0; i < got_o.size() && i < exp_o.size(); i++)
      if (got_o[i] !== exp_o[i]) m++;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic s, input logic e);
    rx_data = d; rx_valid = 1'b1; rx_sof = s; rx_eof = e;
    tick();
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
  endtask

  task automatic send_frm(input int nbytes, input int gap_pct, input logic with_eof);
    for (int i = 0; i < nbytes; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) tick();
      drive_byte(frm[i], i == 0, with_eof && (i == nbytes - 1));
    end
  endtask

  task automatic clear_q();
    got_o.delete(); exp_o.delete(); got_s.delete(); exp_s.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({o_out_data, o_out_valid, o_out_sof, o_out_eof} !== 11'd0) begin
      errors++; $display("FAIL reset_out got %h want 0", {o_out_data, o_out_valid, o_out_sof, o_out_eof});
    end
    checks++;
    if ({o_frame_done, o_fcs_ok, o_fcs_err, o_len_err, o_abort} !== 5'd0) begin
      errors++; $display("FAIL reset_status got %b want 0", {o_frame_done, o_fcs_ok, o_fcs_err, o_len_err, o_abort});
    end
    checks++;
    if (o_byte_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_bytecnt got %0d want 0", o_byte_cnt);
    end
  endtask

  task automatic test_good64();
    st_t e;
    clear_q();
    build_frame(64);
    e = model_frame();
    send_frm(64, 0, 1'b1);
    repeat (3) tick();
    checks++;
    if (got_s.size() !== 1 || got_s[0] !== e) begin
      errors++; $display("FAIL good64_status got n=%0d %h want %h", got_s.size(), got_s.size() ? got_s[0] : '0, e);
    end
    checks++;
    if (out_mism() !== 0 || got_o.size() !== 60) begin
      errors++; $display("FAIL good64_out got %0d bytes (%0d bad) want 60", got_o.size(), out_mism());
    end
  endtask

  // Reuses the frame in frm from test_good64 with one payload bit flipped.
  task automatic test_bad_fcs();
    st_t e;
    clear_q();
    frm[10] = frm[10] ^ 8'h08;
    e = model_frame();
    send_frm(64, 0, 1'b1);
    repeat (3) tick();
    checks++;
    if (got_s.size() !== 1 || got_s[0] !== e || e.err !== 1'b1) begin
      errors++; $display("FAIL badfcs_status got n=%0d %h want %h", got_s.size(), got_s.size() ? got_s[0] : '0, e);
    end
    checks++;
    if (out_mism() !== 0 || got_o.size() !== 60) begin
      errors++; $display("FAIL badfcs_out got %0d bytes (%0d bad) want 60", got_o.size(), out_mism());
    end
  endtask

  task automatic test_length();
    int  lens[3] = '{63, 1519, 1518};
    st_t e;
    for (int k = 0; k < 3; k++) begin
      clear_q();
      build_frame(lens[k]);
      e = model_frame();
      send_frm(lens[k], 0, 1'b1);
      repeat (3) tick();
      checks++;
      if (got_s.size() !== 1 || got_s[0] !== e) begin
        errors++; $display("FAIL len%0d_status got n=%0d %h want %h", lens[k], got_s.size(), got_s.size() ? got_s[0] : '0, e);
      end
      checks++;
      if (out_mism() !== 0 || got_o.size() !== lens[k] - 4) begin
        errors++; $display("FAIL len%0d_out got %0d bytes (%0d bad) want %0d", lens[k], got_o.size(), out_mism(), lens[k] - 4);
      end
    end
  endtask

  task automatic test_abort();
    st_t e;
    clear_q();
    build_frame(64);
    for (int i = 0; i < 16; i++) exp_o.push_back('{frm[i], i == 0, 1'b0});
    send_frm(20, 0, 1'b0);
    build_frame(64);
    e = model_frame();
    send_frm(64, 0, 1'b1);
    repeat (3) tick();
    checks++;
    if (got_s.size() !== 2) begin
      errors++; $display("FAIL abort_npulses got %0d want 2", got_s.size());
    end else begin
      checks++;
      if ({got_s[0].ok, got_s[0].err, got_s[0].len, got_s[0].ab} !== 4'b0001) begin
        errors++; $display("FAIL abort_flags got %b want 0001", {got_s[0].ok, got_s[0].err, got_s[0].len, got_s[0].ab});
      end
      checks++;
      if (got_s[1] !== e) begin
        errors++; $display("FAIL abort_next_status got %h want %h", got_s[1], e);
      end
    end
    checks++;
    if (out_mism() !== 0) begin
      errors++; $display("FAIL abort_out got %0d bytes (%0d bad) want %0d", got_o.size(), out_mism(), exp_o.size());
    end
  endtask

  task automatic test_gaps_reset();
    st_t e;
    clear_q();
    build_frame(64);
    e = model_frame();
    send_frm(64, 30, 1'b1);
    repeat (3) tick();
    checks++;
    if (got_s.size() !== 1 || got_s[0] !== e || out_mism() !== 0) begin
      errors++; $display("FAIL gaps_frame got n=%0d st=%h bad=%0d want st=%h", got_s.size(), got_s.size() ? got_s[0] : '0, out_mism(), e);
    end
    // Reset part-way through a frame: 30 bytes in means 26 bytes out, then everything clears.
    clear_q();
    build_frame(64);
    for (int i = 0; i < 26; i++) exp_o.push_back('{frm[i], i == 0, 1'b0});
    send_frm(30, 20, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({o_out_valid, o_out_sof, o_out_eof, o_frame_done, o_fcs_ok, o_fcs_err, o_len_err, o_abort, o_out_data, o_byte_cnt} !== 32'd0) begin
      errors++; $display("FAIL midreset_outputs got %h want 0",
        {o_out_valid, o_out_sof, o_out_eof, o_frame_done, o_fcs_ok, o_fcs_err, o_len_err, o_abort, o_out_data, o_byte_cnt});
    end
    repeat (3) tick();
    checks++;
    if (got_s.size() !== 0 || out_mism() !== 0) begin
      errors++; $display("FAIL midreset_activity got pulses=%0d bytes=%0d bad=%0d want 0/26/0", got_s.size(), got_o.size(), out_mism());
    end
    clear_q();
    build_frame(64);
    e = model_frame();
    send_frm(64, 10, 1'b1);
    repeat (3) tick();
    checks++;
    if (got_s.size() !== 1 || got_s[0] !== e || e.ok !== 1'b1 || out_mism() !== 0) begin
      errors++; $display("FAIL after_reset_frame got n=%0d st=%h bad=%0d want st=%h", got_s.size(), got_s.size() ? got_s[0] : '0, out_mism(), e);
    end
  endtask

  task automatic test_back_to_back();
    int lens[6];
    lens[0] = 64;
    lens[1] = $urandom_range(2, 4);
    lens[2] = $urandom_range(5, 120);
    lens[3] = 1;
    lens[4] = 64;
    lens[5] = $urandom_range(60, 70);
    clear_q();
    for (int k = 0; k < 6; k++) begin
      build_frame(lens[k]);
      if (k == 2 || (k == 5 && $urandom_range(0, 1) == 1)) frm[0] = frm[0] ^ 8'h01;
      exp_s.push_back(model_frame());
      send_frm(lens[k], 0, 1'b1);
    end
    repeat (3) tick();
    checks++;
    if (got_s.size() !== 6) begin
      errors++; $display("FAIL b2b_npulses got %0d want 6", got_s.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got_s[k] !== exp_s[k]) begin
          errors++; $display("FAIL b2b_status%0d len=%0d got %h want %h", k, lens[k], got_s[k], exp_s[k]);
        end
      end
    end
    checks++;
    if (out_mism() !== 0) begin
      errors++; $display("FAIL b2b_out got %0d bytes (%0d bad) want %0d", got_o.size(), out_mism(), exp_o.size());
    end
  endtask

  task automatic test_saturation();
    st_t e;
    clear_q();
    build_frame(65540);
    e = model_frame();
    send_frm(65540, 0, 1'b1);
    repeat (3) tick();
    checks++;
    if (got_s.size() !== 1 || got_s[0] !== e || e.cnt !== 16'hFFFF) begin
      errors++; $display("FAIL saturate_status got n=%0d %h want %h", got_s.size(), got_s.size() ? got_s[0] : '0, e);
    end
    checks++;
    if (out_mism() !== 0) begin
      errors++; $display("FAIL saturate_out got %0d bytes (%0d bad) want %0d", got_o.size(), out_mism(), exp_o.size());
    end
  endtask

  task automatic test_quiet();
    checks++;
    if (leak !== 0) begin
      errors++; $display("FAIL unqualified_outputs got %0d cycles want 0", leak);
    end
  endtask

  initial begin
    test_reset();
    test_good64();
    test_bad_fcs();
    test_length();
    test_abort();
    test_gaps_reset();
    test_back_to_back();
    test_saturation();
    test_quiet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
